vreg_wb_sequencer: RTL
======================

// Module: vreg_wb_sequencer
// PURPOSE
//   Write-side front end for a vector register file (32 x DATA_W, one write port).
//   Two producers can request writebacks: the vector ALU and the vector load unit.
//   Both use valid/ready handshakes. The block arbitrates between them round-robin
//   and buffers accepted requests in a FIFO. It drains one entry per cycle onto the
//   registered reg_write/write_reg/write_data port. It also exports a per-register
//   pending-write mask so decode can stall on RAW hazards.
// PARAMETERS
//   DATA_W     32  element/data width
//   ADDR_W     5   register index width (32 registers)
//   FIFO_DEPTH 4   buffer entries; power of 2, >=2
// PORTS
//   clk        in   1                   clock; all state updates on posedge
//   rst        in   1                   reset, synchronous, active-low
//   alu_valid  in   1                   ALU writeback request valid
//   alu_ready  out  1                   ALU request accepted this cycle when high with alu_valid
//   alu_reg    in   ADDR_W              ALU destination register
//   alu_data   in   DATA_W              ALU result
//   ld_valid   in   1                   load-unit writeback request valid
//   ld_ready   out  1                   load request accepted this cycle when high with ld_valid
//   ld_reg     in   ADDR_W              load destination register
//   ld_data    in   DATA_W              load data
//   reg_write  out  1                   write strobe to register file (registered)
//   write_reg  out  ADDR_W              write index (registered)
//   write_data out  DATA_W              write data (registered)
//   busy_mask  out  32                  bit r = write to register r still pending
//   idle       out  1                   FIFO empty and reg_write low
// BEHAVIOUR
//   Reset: rst is synchronous and active-low; clock is clk. While rst==0 at posedge:
//     - FIFO pointers and count go to 0 (queued entries are discarded, including mid-burst).
//     - reg_write=0, write_reg=0, write_data=0.
//     - last_grant=LD, so the ALU wins the first tie.
//     - Resulting outputs: busy_mask=0, idle=1.
//   Arbitration (combinational from valids, full and last_grant):
//     - At most one request is accepted per cycle.
//     - Only alu_valid -> alu_ready=!full. Only ld_valid -> ld_ready=!full.
//     - Both valid -> the source not equal to last_grant gets ready=!full; the other gets 0.
//     - No valid input -> both readies 0.
//     - last_grant updates to the accepted source on each accept. It holds otherwise.
//     - full = (count==FIFO_DEPTH). A same-cycle pop does NOT free a slot for an
//       enqueue in that cycle (no full bypass).
//   Enqueue:
//     - An accepted request with reg!=0 is written at the tail: tail++, count++.
//     - An accepted request with reg==0 completes its handshake but is dropped.
//       Register 0 reads as zero, so it causes no FIFO entry, no busy bit and no write.
//   Drain: at each posedge with count>0:
//     - The head is popped into write_reg/write_data, reg_write<=1, head++, count--.
//     - With count==0, reg_write<=0. write_reg and write_data hold their last values.
//   Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
//   Pointers wrap modulo FIFO_DEPTH.
//   Latency: request accepted at edge N into an empty FIFO -> reg_write=1 after
//     edge N+1 -> register file captures at edge N+2.
//   Throughput: 1 write per cycle sustained. Write order = acceptance order.
//   busy_mask (combinational from state):
//     - bit r = OR over valid FIFO entries with reg==r, OR (reg_write && write_reg==r).
//     - Bit 0 is always 0.
//     - Duplicate destinations keep the bit set until the last queued write is on the port.
//   idle = (count==0) && !reg_write.
//   Inputs must be stable while valid && !ready. Behaviour is undefined otherwise.
// TESTING
//   1) Reset flush: fill 3 entries, pulse rst low 1 cycle -> count=0, reg_write=0,
//      busy_mask=0, idle=1, and no writes of the flushed entries follow.
//   2) Single write: alu_valid, reg=5, data=0xDEADBEEF at edge N.
//      -> busy_mask[5]=1 from N.
//      -> reg_write=1, write_reg=5, write_data=0xDEADBEEF in cycle after N+1.
//      -> busy_mask[5]=0 and idle=1 after N+2.
//   3) Tie round-robin: both valid every cycle (alu reg 1..4, ld reg 11..14)
//      -> accept order ALU1, LD11, ALU2, LD12, ... and reg_write sequence identical.
//   4) Full/backpressure: stall drain is impossible, so hold both producers valid for
//      8 cycles while injecting every cycle.
//      -> count never exceeds 4.
//      -> readies are 0 whenever count==4.
//      -> no request lost or duplicated; the scoreboard matches the write order.
//   5) reg 0: ld_valid reg=0, data=0x1234
//      -> ld_ready=1, count unchanged, no reg_write, busy_mask=0.
//   6) Duplicate destination: ALU reg 7 = 0xA then LD reg 7 = 0xB back-to-back
//      -> two writes in order A, B.
//      -> busy_mask[7] stays 1 until after the write of 0xB leaves the port.

Source files
------------

// File: rtl/vreg_wb_sequencer_if.sv
// Writeback bundle between the two producers, the sequencer and the register file port.
// "slave" is the sequencer side; "master" is the producer/consumer side.
interface vreg_wb_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                    alu_valid;
  logic                    alu_ready;
  logic [ADDR_W-1:0]       alu_reg;
  logic [DATA_W-1:0]       alu_data;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [ADDR_W-1:0]       ld_reg;
  logic [DATA_W-1:0]       ld_data;
  logic                    reg_write;
  logic [ADDR_W-1:0]       write_reg;
  logic [DATA_W-1:0]       write_data;
  logic [(1<<ADDR_W)-1:0]  busy_mask;
  logic                    idle;

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    output alu_ready, ld_ready, reg_write, write_reg, write_data, busy_mask, idle
  );

  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    input  alu_ready, ld_ready, reg_write, write_reg, write_data, busy_mask, idle
  );
endinterface

// File: rtl/vreg_wb_sequencer.sv
// Round-robin writeback sequencer: arbitrates ALU and load-unit requests into a small FIFO
// and drains one entry per cycle onto a registered register-file write port.
module vreg_wb_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  vreg_wb_sequencer_if.slave wb
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;

  logic [ADDR_W-1:0]   fifo_reg_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];

  logic                full;
  logic                alu_win, ld_win;
  logic                alu_acc, ld_acc;
  logic [ADDR_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   acc_data;
  logic                push, pop;
  logic [NUM_REGS-1:0] busy;

  // Full is judged on the registered count only: a pop in the same cycle never frees a slot.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    alu_win  = wb.alu_valid && (!wb.ld_valid || (last_grant_q == GRANT_LD));
    ld_win   = wb.ld_valid && (!wb.alu_valid || (last_grant_q == GRANT_ALU));
    alu_acc  = alu_win && !full;
    ld_acc   = ld_win && !full;
    acc_reg  = alu_acc ? wb.alu_reg : wb.ld_reg;
    acc_data = alu_acc ? wb.alu_data : wb.ld_data;
    push     = (alu_acc || ld_acc) && (acc_reg != '0);
    pop      = (count_q != '0);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_acc) begin
      last_grant_d = GRANT_ALU;
    end else if (ld_acc) begin
      last_grant_d = GRANT_LD;
    end
    tail_d       = push ? (tail_q + 1'b1) : tail_q;
    head_d       = pop ? (head_q + 1'b1) : head_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    reg_write_d  = pop;
    write_reg_d  = pop ? fifo_reg_q[head_q] : write_reg_q;
    write_data_d = pop ? fifo_data_q[head_q] : write_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= GRANT_LD;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_reg_q[tail_q]  <= acc_reg;
      fifo_data_q[tail_q] <= acc_data;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        busy[fifo_reg_q[head_q + PTR_W'(k)]] = 1'b1;
      end
    end
    if (reg_write_q) begin
      busy[write_reg_q] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign wb.alu_ready  = alu_acc;
  assign wb.ld_ready   = ld_acc;
  assign wb.reg_write  = reg_write_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;
  assign wb.busy_mask  = busy;
  assign wb.idle       = (count_q == '0) && !reg_write_q;

endmodule
